mac_dot_engine: RTL and testbench
=================================

# mac_dot_engine

Pipelined, multi-lane signed dot-product MAC, the parametrised successor to the single-lane LUT MAC unit. Each accepted beat carries `LANES` operand pairs that are multiplied exactly, reduced through an adder tree and accumulated across a vector delimited by `first`/`last` flags. A valid/ready handshake on both sides lets it sit between an operand streamer and a result FIFO in the datapath. One result is emitted per completed vector, together with an overflow flag and a beat count.

## Interface
- `DATA_WIDTH`, 16, signed operand width per lane
- `ACC_WIDTH`, 40, signed accumulator/result width; must be ≥ 2*DATA_WIDTH + $clog2(LANES) (elaboration error otherwise)
- `LANES`, 4, operand pairs per beat; power of two, 1..16
- `CNT_WIDTH`, 16, width of beat counter

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous flush: drops all in-flight beats, zeroes accumulator, deasserts `out_valid`
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  block can accept a beat
- `in_a`  in  LANES*DATA_WIDTH  packed signed operands, lane 0 in LSBs
- `in_b`  in  LANES*DATA_WIDTH  packed signed operands, lane 0 in LSBs
- `in_first`  in  1  beat opens a new vector
- `in_last`  in  1  beat closes the vector
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_result`  out  ACC_WIDTH  signed dot product
- `out_count`  out  CNT_WIDTH  beats accumulated into this result (saturates at all-ones)
- `out_ovf`  out  1  accumulation exceeded ACC_WIDTH range for this vector

## Operation
- Stage S1: register LANES full-precision products (2*DATA_WIDTH each) plus first/last/valid.
- Stage S2: register sign-extended adder-tree sum, width 2*DATA_WIDTH + $clog2(LANES).
- Stage S3: accumulate. If beat has `first`, or no vector is open, acc = sum, count = 1; else acc = acc + sum (computed at ACC_WIDTH+1 bits), count++.
- On an S3 beat with `last`: load `out_result`/`out_count`/`out_ovf`, assert `out_valid`, close the vector; accumulator holds its value until next beat.
- `out_ovf` is sticky within a vector, cleared on the first beat of the next vector.
- Global stall: `advance = !out_valid || out_ready`; `in_ready = advance`. When `advance` is low every stage, the accumulator and outputs hold.
- `in_first` and `in_last` on the same beat: single-beat vector, result = that beat's sum.
- `in_first` mid-vector: discards the open partial sum and restarts (no result emitted for the abandoned vector).
- `clear` has priority over handshakes; `clear` with `in_valid` high drops that beat.
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_count`=0, `out_ovf`=0; all stage valids 0, no vector open.

## Timing
- Latency: beat accepted at edge t with `last` → `out_valid` high after edge t+3.
- Throughput: one beat per cycle while unstalled; result consumed in the same cycle it is presented (`out_valid && out_ready`) causes no bubble.
- `in_ready` is combinational from `out_valid` and `out_ready` only; no combinational path from `in_valid` to `in_ready`.
- Outputs stable while `out_valid && !out_ready`.
- Reset deassertion mid-operation: all in-flight beats lost; first accepted beat afterwards opens a new vector.

## Configuration
- `MAC_DOT_SATURATE_EN` defined: S3 clamps acc to ±(2^(ACC_WIDTH-1)) bounds (max 2^(ACC_WIDTH-1)-1, min −2^(ACC_WIDTH-1)) on overflow and sets `out_ovf`; later beats accumulate from the clamped value.
- Undefined: two's-complement wrap at ACC_WIDTH; `out_ovf` still detects and reports the wrap, no clamping.

## Test plan
- Reset, LANES=4: single beat a={1,2,3,4}, b={5,6,7,8}, first=last=1 → out_result=70, out_count=1, out_valid 3 cycles after accept.
- Three-beat vector, all lanes a=−3, b=7 → out_result=−252, out_count=3; back-to-back second vector with out_ready=1 shows no bubble.
- Hold out_ready=0 for 5 cycles with result pending → in_ready=0, result/count stable, no beats lost after release.
- ACC_WIDTH=33, DATA_WIDTH=16: accumulate a=b=−32768 on all lanes over 2 beats → with macro out_result=2^32−1, out_ovf=1; without, wrapped value, out_ovf=1.
- Assert clear with two beats in flight → out_valid never rises for them; next first/last beat a={1,1,1,1}, b={1,1,1,1} yields 4.
- Drop reset mid-vector, then send beat without `first`, last=1, products sum 10 → out_result=10, out_count=1.

Source files
------------

// File: rtl/mac_dot_engine_if.sv
// mac_dot_engine_if: operand-in / result-out valid/ready handshake bundle for mac_dot_engine.
interface mac_dot_engine_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                               in_valid;
  logic                               in_ready;
  logic        [LANES*DATA_WIDTH-1:0] in_a;
  logic        [LANES*DATA_WIDTH-1:0] in_b;
  logic                               in_first;
  logic                               in_last;
  logic                               out_valid;
  logic                               out_ready;
  logic signed [ACC_WIDTH-1:0]        out_result;
  logic        [CNT_WIDTH-1:0]        out_count;
  logic                               out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, out_ready,
    output in_ready, out_valid, out_result, out_count, out_ovf
  );
endinterface

// File: rtl/mac_dot_engine.sv
// mac_dot_engine: pipelined LANES-wide signed dot-product MAC (products, reduction, accumulate,
// result register). Define MAC_DOT_SATURATE_EN to clamp on accumulator overflow instead of wrap.
module mac_dot_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic             clk,
  input logic             reset,
  input logic             clear,
  mac_dot_engine_if.slave bus
);
  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned SumW  = ProdW + $clog2(LANES);

  if (ACC_WIDTH < SumW) begin : g_acc_width_check
    $error("mac_dot_engine: ACC_WIDTH must be >= 2*DATA_WIDTH + clog2(LANES)");
  end
  if (LANES < 1 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_lanes_check
    $error("mac_dot_engine: LANES must be a power of two in 1..16");
  end

  logic advance;
  logic out_valid_q;

  // Whole pipeline moves as one; only a pending, unconsumed result stalls it.
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // S1: exact lane products
  logic signed [ProdW-1:0] prod_d    [LANES];
  logic signed [ProdW-1:0] s1_prod_q [LANES];
  logic                    s1_valid_q, s1_first_q, s1_last_q;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_d[i] = ProdW'($signed(bus.in_a[i*DATA_WIDTH +: DATA_WIDTH])) *
                  ProdW'($signed(bus.in_b[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      s1_first_q <= bus.in_first;
      s1_last_q  <= bus.in_last;
      s1_prod_q  <= prod_d;
    end
  end

  // S2: reduction of the lane products
  logic signed [SumW-1:0] sum_d, s2_sum_q;
  logic                   s2_valid_q, s2_first_q, s2_last_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < LANES; i++) sum_d = sum_d + SumW'(s1_prod_q[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
    end else if (clear) begin
      s2_valid_q <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_sum_q   <= sum_d;
    end
  end

  // S3: accumulate across the vector
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH:0]   acc_base, acc_wide;
  logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                        ovf_q, ovf_d, open_q, start, wide_ovf;
  logic                        s3_valid_q, s3_last_q;

  always_comb begin
    start    = s2_first_q || !open_q;
    acc_base = start ? '0 : (ACC_WIDTH+1)'(acc_q);
    acc_wide = acc_base + (ACC_WIDTH+1)'(s2_sum_q);
    wide_ovf = acc_wide[ACC_WIDTH] ^ acc_wide[ACC_WIDTH-1];
    acc_d    = acc_wide[ACC_WIDTH-1:0];
`ifdef MAC_DOT_SATURATE_EN
    if (wide_ovf) begin
      acc_d = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
    ovf_d = (start ? 1'b0 : ovf_q) | wide_ovf;
    cnt_d = start ? CNT_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      open_q     <= 1'b0;
    end else if (clear) begin
      s3_valid_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      open_q     <= 1'b0;
    end else if (advance) begin
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      if (s2_valid_q) begin
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
        open_q <= !s2_last_q;
      end
    end
  end

  // Result register: loaded when a vector-closing beat leaves S3
  logic signed [ACC_WIDTH-1:0] out_result_q;
  logic        [CNT_WIDTH-1:0] out_count_q;
  logic                        out_ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= s3_valid_q && s3_last_q;
      if (s3_valid_q && s3_last_q) begin
        out_result_q <= acc_q;
        out_count_q  <= cnt_q;
        out_ovf_q    <= ovf_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_count  = out_count_q;
  assign bus.out_ovf    = out_ovf_q;
endmodule

// File: tb/tb_mac_dot_engine.sv
// tb_mac_dot_engine: vector table, corner-case sequences and random traffic for mac_dot_engine,
// checked against an arithmetic model of the dot-product accumulation rules.
module tb_mac_dot_engine;
  localparam int DW     = 16;
  localparam int LANES  = 4;
  localparam int ACC    = 40;
  localparam int CNTW   = 16;
  localparam int LANES2 = 2;
  localparam int ACC2   = 33;

  localparam longint AccMax = (longint'(1) << (ACC - 1)) - 1;
  localparam longint AccMin = -(longint'(1) << (ACC - 1));
  localparam longint Span   = longint'(1) << ACC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic clear2 = 1'b0;
  always #5 clk = ~clk;

  mac_dot_engine_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC), .LANES(LANES), .CNT_WIDTH(CNTW)) bus ();
  mac_dot_engine_if #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC2), .LANES(LANES2), .CNT_WIDTH(CNTW)) bus2 ();

  mac_dot_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC), .LANES(LANES), .CNT_WIDTH(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  mac_dot_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC2), .LANES(LANES2), .CNT_WIDTH(CNTW)) dut2 (
    .clk   (clk),
    .reset (reset),
    .clear (clear2),
    .bus   (bus2)
  );

  typedef struct {
    logic [LANES*DW-1:0] a;
    logic [LANES*DW-1:0] b;
    bit                  first;
    bit                  last;
    bit                  chk;
    longint              res;
    int                  cnt;
  } vec_t;

  typedef struct {longint res; int cnt; bit ovf;} res_t;
  typedef struct {longint res; int cnt; bit ovf; int cyc;} got_t;

  res_t   exp_q[$];
  got_t   got_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     m_open = 1'b0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  bit     hold_v = 1'b0;
  longint hold_res = 0;
  int     hold_cnt = 0;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic longint beat_sum(logic [LANES*DW-1:0] a, logic [LANES*DW-1:0] b);
    longint s = 0;
    for (int i = 0; i < LANES; i++)
      s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
    return s;
  endfunction

  task automatic model_beat(logic [LANES*DW-1:0] a, logic [LANES*DW-1:0] b, bit first, bit last);
    if (first || !m_open) begin
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    m_acc += beat_sum(a, b);
    if (m_acc > AccMax || m_acc < AccMin) begin
      m_ovf = 1'b1;
`ifdef MAC_DOT_SATURATE_EN
      m_acc = (m_acc > AccMax) ? AccMax : AccMin;
`else
      m_acc = (m_acc > AccMax) ? m_acc - Span : m_acc + Span;
`endif
    end
    if (m_cnt < 65535) m_cnt++;
    if (last) begin
      exp_q.push_back('{m_acc, m_cnt, m_ovf});
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    m_open = 1'b0;
    hold_v = 1'b0;
  endtask

  // Evaluate one cycle's handshakes shortly after the falling edge, then wait for the next one.
  task automatic step();
    got_t g;
    res_t e;
    #1;
    if (hold_v) begin
      chk("hold_valid", longint'(bus.out_valid), 1);
      chk("hold_result", $signed(bus.out_result), hold_res);
      chk("hold_count", longint'(bus.out_count), hold_cnt);
    end
    hold_v   = bus.out_valid && !bus.out_ready && !clear;
    hold_res = $signed(bus.out_result);
    hold_cnt = bus.out_count;
    if (bus.out_valid && bus.out_ready) begin
      g.res = $signed(bus.out_result);
      g.cnt = bus.out_count;
      g.ovf = bus.out_ovf;
      g.cyc = cyc;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected no result", g.res);
      end else begin
        e = exp_q.pop_front();
        chk("result", g.res, e.res);
        chk("count", g.cnt, e.cnt);
        chk("ovf", longint'(g.ovf), longint'(e.ovf));
      end
    end
    if (clear) model_flush();
    else if (bus.in_valid && bus.in_ready)
      model_beat(bus.in_a, bus.in_b, bus.in_first, bus.in_last);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic send(logic [LANES*DW-1:0] a, logic [LANES*DW-1:0] b, bit first, bit last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_first = first;
    bus.in_last  = last;
    step();
  endtask

  task automatic drain(string name, int budget);
    idle();
    for (int k = 0; k < budget && exp_q.size() > 0; k++) step();
    chk(name, exp_q.size(), 0);
  endtask

  function automatic logic [LANES*DW-1:0] rnd_vec();
    if ($urandom % 8 == 0) return {LANES{16'h8000}};
    return {$urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   k;
    int   n;
    int   c0;

    tbl[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1, 1, 1, 70, 1};
    tbl[1] = '{{4{16'hFFFD}}, {4{16'd7}}, 1, 0, 0, 0, 0};
    tbl[2] = '{{4{16'hFFFD}}, {4{16'd7}}, 0, 0, 0, 0, 0};
    tbl[3] = '{{4{16'hFFFD}}, {4{16'd7}}, 0, 1, 1, -252, 3};
    tbl[4] = '{{4{16'h8000}}, {4{16'h8000}}, 1, 1, 1, 64'd4294967296, 1};
    tbl[5] = '{{16'hFFFF, 16'h0064, 16'h8000, 16'h7FFF},
               {16'hFFFF, 16'hFFFB, 16'h7FFF, 16'h7FFF}, 1, 1, 1, -33266, 1};
    tbl[6] = '{{4{16'd9}}, {4{16'd9}}, 1, 0, 0, 0, 0};
    tbl[7] = '{{4{16'd1}}, {4{16'd2}}, 1, 1, 1, 8, 1};

    idle();
    bus2.in_valid = 1'b0;  bus2.in_first = 1'b0; bus2.in_last = 1'b0;
    bus2.in_a = '0;        bus2.in_b = '0;       bus2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_result", $signed(bus.out_result), 0);
    chk("rst_out_count", longint'(bus.out_count), 0);
    chk("rst_out_ovf", longint'(bus.out_ovf), 0);
    reset = 1'b1;
    @(negedge clk);

    // Table: back-to-back beats with the consumer always ready
    got_q.delete();
    for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].first, tbl[i].last);
    drain("table_drain", 20);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].chk) begin
        if (k < got_q.size()) begin
          chk("table_result", got_q[k].res, tbl[i].res);
          chk("table_count", got_q[k].cnt, tbl[i].cnt);
          chk("table_ovf", longint'(got_q[k].ovf), 0);
        end else begin
          checks++;
          errors++;
          $display("FAIL table_missing: got %0d results expected row %0d", got_q.size(), i);
        end
        k++;
      end
    end
    if (got_q.size() >= 3) chk("no_bubble", got_q[2].cyc - got_q[1].cyc, 1);
    else chk("no_bubble_count", got_q.size(), 5);

    // Latency: accept sampled at edge t, result visible in the cycle after edge t+3
    repeat (3) step();
    got_q.delete();
    c0 = cyc;
    send(tbl[0].a, tbl[0].b, 1, 1);
    idle();
    for (int j = 0; j < 10 && got_q.size() == 0; j++) step();
    if (got_q.size() > 0) chk("latency", got_q[0].cyc - c0, 4);
    else chk("latency_seen", 0, 1);

    // Overflow on the narrow instance: two beats of 2 * (-32768)^2 = 2^32 total past 2^32-1
    bus2.in_valid = 1'b1; bus2.in_first = 1'b1; bus2.in_last = 1'b0;
    bus2.in_a = {2{16'h8000}}; bus2.in_b = {2{16'h8000}};
    @(negedge clk);
    bus2.in_first = 1'b0; bus2.in_last = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
    for (int j = 0; j < 10 && !bus2.out_valid; j++) @(negedge clk);
    chk("ovf2_valid", longint'(bus2.out_valid), 1);
`ifdef MAC_DOT_SATURATE_EN
    chk("ovf2_result", $signed(bus2.out_result), (longint'(1) << 32) - 1);
`else
    chk("ovf2_result", $signed(bus2.out_result), -(longint'(1) << 32));
`endif
    chk("ovf2_count", longint'(bus2.out_count), 2);
    chk("ovf2_flag", longint'(bus2.out_ovf), 1);

    // Long vector overflowing the 40-bit accumulator, then a clean vector (sticky flag clears)
    got_q.delete();
    for (int i = 0; i < 130; i++) send({4{16'h8000}}, {4{16'h8000}}, i == 0, i == 129);
    send(tbl[7].a, tbl[7].b, 1, 1);
    drain("long_drain", 20);
    if (got_q.size() == 2) begin
      chk("long_ovf", longint'(got_q[0].ovf), 1);
      chk("long_count", got_q[0].cnt, 130);
      chk("after_ovf_clear", longint'(got_q[1].ovf), 0);
    end else chk("long_results", got_q.size(), 2);

    // Back-pressure: result held for 5 cycles while beats keep being offered
    bus.out_ready = 1'b0;
    send(tbl[0].a, tbl[0].b, 1, 1);
    for (int j = 0; j < 10 && !bus.out_valid; j++) send(rnd_vec(), rnd_vec(), 1, 1);
    chk("stall_valid_seen", longint'(bus.out_valid), 1);
    for (int j = 0; j < 5; j++) begin
      chk("stall_in_ready", longint'(bus.in_ready), 0);
      send(rnd_vec(), rnd_vec(), 1, 1);
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) send(rnd_vec(), rnd_vec(), j == 0, j == 4);
    drain("stall_drain", 20);

    // Clear with two beats in flight, and a beat offered during clear
    send(rnd_vec(), rnd_vec(), 1, 0);
    send(rnd_vec(), rnd_vec(), 0, 1);
    clear = 1'b1;
    send(rnd_vec(), rnd_vec(), 1, 1);
    clear = 1'b0;
    idle();
    n = 0;
    for (int j = 0; j < 8; j++) begin
      if (bus.out_valid) n++;
      step();
    end
    chk("clear_no_output", n, 0);
    got_q.delete();
    send({4{16'd1}}, {4{16'd1}}, 1, 1);
    drain("clear_drain", 20);
    if (got_q.size() > 0) chk("clear_then_4", got_q[0].res, 4);
    else chk("clear_then_seen", 0, 1);

    // Reset mid-vector; next beat without first still opens a new vector
    send(rnd_vec(), rnd_vec(), 1, 0);
    send(rnd_vec(), rnd_vec(), 0, 0);
    reset = 1'b0;
    model_flush();
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got_q.delete();
    send({16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd1}}, 0, 1);
    drain("reset_drain", 20);
    if (got_q.size() > 0) begin
      chk("reset_result", got_q[0].res, 10);
      chk("reset_count", got_q[0].cnt, 1);
    end else chk("reset_seen", 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom % 3) != 0;
      clear         = ($urandom % 97) == 0;
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_first  = ($urandom % 6) == 0;
      bus.in_last   = ($urandom % 3) == 0;
      bus.in_a      = rnd_vec();
      bus.in_b      = rnd_vec();
      step();
    end
    clear = 1'b0;
    drain("final_drain", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
